// File: rtl/tft_timing_pkg.sv
// Shared constants and types for the 800x480 RGB565 TFT raster path.
// Holds the default sync/porch geometry, the derived line and frame totals,
// the RGB565 pixel type and the idle value of the sync pipeline entry.
// The pixel-source stage imports the same constants so both ends agree
// on the visible window.
package tft_timing_pkg;

  localparam int H_SYNC_DEF  = 1;
  localparam int H_BACK_DEF  = 46;
  localparam int H_DISP_DEF  = 800;
  localparam int H_FRONT_DEF = 210;
  localparam int H_TOTAL     = H_SYNC_DEF + H_BACK_DEF + H_DISP_DEF + H_FRONT_DEF;

  localparam int V_SYNC_DEF  = 1;
  localparam int V_BACK_DEF  = 23;
  localparam int V_DISP_DEF  = 480;
  localparam int V_FRONT_DEF = 22;
  localparam int V_TOTAL     = V_SYNC_DEF + V_BACK_DEF + V_DISP_DEF + V_FRONT_DEF;

  localparam int PIX_LAT_DEF = 1;

  typedef logic [15:0] pixel_t;
  localparam pixel_t RGB_BLACK = 16'h0000;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic first;
  } sync_t;

  // Inactive panel levels: syncs deasserted (high), no data enable.
  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, first: 1'b0};

endpackage

// File: rtl/tft_sync_pipe.sv
// Fixed-depth shift register carrying {hs, vs, de, first} so the panel
// control pins line up with pixel data returned by the pixel source.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_hs/i_vs/i_de/i_first    stage-0 controls from the counters
//   o_hs/o_vs/o_de/o_first    controls delayed by STAGES clocks
//   o_tap_de                  de delayed by TAP clocks (TAP = 0 is the input)
module tft_sync_pipe
  import tft_timing_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int TAP    = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_hs,
  input  logic i_vs,
  input  logic i_de,
  input  logic i_first,
  output logic o_hs,
  output logic o_vs,
  output logic o_de,
  output logic o_first,
  output logic o_tap_de
);

  sync_t r_sync_p [STAGES];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < STAGES; i++) r_sync_p[i] <= SYNC_IDLE;
    end else begin
      r_sync_p[0] <= '{hs: i_hs, vs: i_vs, de: i_de, first: i_first};
      for (int i = 1; i < STAGES; i++) r_sync_p[i] <= r_sync_p[i-1];
    end
  end

  assign o_hs    = r_sync_p[STAGES-1].hs;
  assign o_vs    = r_sync_p[STAGES-1].vs;
  assign o_de    = r_sync_p[STAGES-1].de;
  assign o_first = r_sync_p[STAGES-1].first;

  // With zero pixel-source latency the data returns in the addressing
  // cycle itself, so the gate must come straight from the input.
  generate
    if (TAP == 0) begin : g_tap_in
      assign o_tap_de = i_de;
    end else begin : g_tap_reg
      assign o_tap_de = r_sync_p[TAP-1].de;
    end
  endgenerate

endmodule

// File: rtl/tft_timing_driver.sv
// Raster timing generator and panel output stage for the 800x480 RGB565
// TFT panel. Scans horizontal/vertical counters, issues the visible pixel
// coordinate to the pixel source, captures the returned pixel and drives
// hsync/vsync/de/RGB delayed to stay aligned with that pixel.
// Ports:
//   clk_33_3m     pixel clock
//   rst           synchronous active-high reset
//   x_pos, y_pos  visible pixel coordinate (0 outside the active area)
//   data_req      high while x_pos/y_pos address a visible pixel
//   display_data  RGB565 from the pixel source, PIX_LAT clocks after data_req
//   tft_hs/tft_vs active-low syncs
//   tft_de        active-high data enable
//   tft_rgb       RGB565 to the panel, black outside de
//   frame_start   one-clock pulse with the first de of each frame
module tft_timing_driver
  import tft_timing_pkg::*;
#(
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BACK  = H_BACK_DEF,
  parameter int H_DISP  = H_DISP_DEF,
  parameter int H_FRONT = H_FRONT_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BACK  = V_BACK_DEF,
  parameter int V_DISP  = V_DISP_DEF,
  parameter int V_FRONT = V_FRONT_DEF,
  parameter int PIX_LAT = PIX_LAT_DEF
) (
  input  logic        clk_33_3m,
  input  logic        rst,
  output logic [10:0] x_pos,
  output logic [10:0] y_pos,
  output logic        data_req,
  input  logic [15:0] display_data,
  output logic        tft_hs,
  output logic        tft_vs,
  output logic        tft_de,
  output logic [15:0] tft_rgb,
  output logic        frame_start
);

  localparam logic [10:0] H_LAST     = 11'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
  localparam logic [10:0] H_ACT_BEG  = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_ACT_END  = 11'(H_SYNC + H_BACK + H_DISP);
  localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
  localparam logic [9:0]  V_ACT_BEG  = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_ACT_END  = 10'(V_SYNC + V_BACK + V_DISP);
  localparam logic [9:0]  V_SYNC_END = 10'(V_SYNC);

  logic [10:0] r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic [10:0] r_x_pos;
  logic [10:0] r_y_pos;
  logic        r_data_req;
  pixel_t      r_rgb;

  logic        w_h_last;
  logic [10:0] w_h_nxt;
  logic [9:0]  w_v_nxt;
  logic        w_act_nxt;
  logic        w_hs_p0;
  logic        w_vs_p0;
  logic        w_de_p0;
  logic        w_first_p0;
  logic        w_tap_de;

  // Counter-next logic; coordinates are registered from the next values so
  // they are valid in the same cycle as the counters they describe.
  assign w_h_last  = (r_h_cnt == H_LAST);
  assign w_h_nxt   = w_h_last ? 11'd0 : r_h_cnt + 11'd1;
  assign w_v_nxt   = !w_h_last ? r_v_cnt :
                     (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
  assign w_act_nxt = (w_h_nxt >= H_ACT_BEG) && (w_h_nxt < H_ACT_END) &&
                     (w_v_nxt >= V_ACT_BEG) && (w_v_nxt < V_ACT_END);

  always_ff @(posedge clk_33_3m) begin
    if (rst) begin
      r_h_cnt    <= '0;
      r_v_cnt    <= '0;
      r_x_pos    <= '0;
      r_y_pos    <= '0;
      r_data_req <= 1'b0;
    end else begin
      r_h_cnt    <= w_h_nxt;
      r_v_cnt    <= w_v_nxt;
      r_data_req <= w_act_nxt;
      r_x_pos    <= w_act_nxt ? (w_h_nxt - H_ACT_BEG) : 11'd0;
      r_y_pos    <= w_act_nxt ? {1'b0, w_v_nxt - V_ACT_BEG} : 11'd0;
    end
  end

  assign x_pos    = r_x_pos;
  assign y_pos    = r_y_pos;
  assign data_req = r_data_req;

  // Stage 0: controls for the pixel currently being addressed
  assign w_hs_p0    = (r_h_cnt >= H_SYNC_END);
  assign w_vs_p0    = (r_v_cnt >= V_SYNC_END);
  assign w_de_p0    = r_data_req;
  assign w_first_p0 = r_data_req && (r_x_pos == 11'd0) && (r_y_pos == 11'd0);

  // Stages 1..PIX_LAT+1: delay controls to match the pixel-source return
  tft_sync_pipe #(
    .STAGES (PIX_LAT + 1),
    .TAP    (PIX_LAT)
  ) u_sync_pipe (
    .i_clk    (clk_33_3m),
    .i_rst    (rst),
    .i_hs     (w_hs_p0),
    .i_vs     (w_vs_p0),
    .i_de     (w_de_p0),
    .i_first  (w_first_p0),
    .o_hs     (tft_hs),
    .o_vs     (tft_vs),
    .o_de     (tft_de),
    .o_first  (frame_start),
    .o_tap_de (w_tap_de)
  );

  // Final stage: capture returned pixel; blank anything outside de so stale
  // source data never reaches the panel.
  always_ff @(posedge clk_33_3m) begin
    if (rst) begin
      r_rgb <= RGB_BLACK;
    end else begin
      r_rgb <= w_tap_de ? display_data : RGB_BLACK;
    end
  end

  assign tft_rgb = r_rgb;

endmodule

// File: tb/tb_tft_timing_driver.sv
// Bench for tft_timing_driver: three instances (full panel geometry with
// PIX_LAT=1, a reduced geometry with PIX_LAT=2, a tiny geometry with
// PIX_LAT=0), each fed by a stub pixel source returning {y[4:0], x[10:0]}
// and random garbage outside data_req. Every output is compared each cycle
// against a model that derives raster position from the cycle count since
// the last reset.
module tb_tft_timing_driver;

  typedef struct packed {
    int hs; int hb; int hd; int hf;
    int vs; int vb; int vd; int vf;
    int lat;
  } geom_t;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        req;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [15:0] rgb;
  } exp_t;

  localparam geom_t GA = '{hs: 1, hb: 46, hd: 800, hf: 210, vs: 1, vb: 23, vd: 480, vf: 22, lat: 1};
  localparam geom_t GB = '{hs: 2, hb: 3,  hd: 10,  hf: 4,   vs: 2, vb: 2,  vd: 6,   vf: 3,  lat: 2};
  localparam geom_t GC = '{hs: 1, hb: 1,  hd: 5,   hf: 2,   vs: 1, vb: 1,  vd: 3,   vf: 1,  lat: 0};
  localparam int NCYC  = 30000;

  logic        clk;
  logic        rst          [3];
  logic [10:0] x_pos        [3];
  logic [10:0] y_pos        [3];
  logic        data_req     [3];
  logic [15:0] display_data [3];
  logic        tft_hs       [3];
  logic        tft_vs       [3];
  logic        tft_de       [3];
  logic [15:0] tft_rgb      [3];
  logic        frame_start  [3];

  int total = 0;
  int bad   = 0;

  geom_t       geo      [3];
  int          k        [3];
  int          rst_left [3];
  logic [15:0] stub     [3][4];
  bit          mid_done;

  tft_timing_driver #(
    .H_SYNC(GA.hs), .H_BACK(GA.hb), .H_DISP(GA.hd), .H_FRONT(GA.hf),
    .V_SYNC(GA.vs), .V_BACK(GA.vb), .V_DISP(GA.vd), .V_FRONT(GA.vf),
    .PIX_LAT(GA.lat)
  ) dut_a (
    .clk_33_3m(clk), .rst(rst[0]), .x_pos(x_pos[0]), .y_pos(y_pos[0]),
    .data_req(data_req[0]), .display_data(display_data[0]),
    .tft_hs(tft_hs[0]), .tft_vs(tft_vs[0]), .tft_de(tft_de[0]),
    .tft_rgb(tft_rgb[0]), .frame_start(frame_start[0])
  );

  tft_timing_driver #(
    .H_SYNC(GB.hs), .H_BACK(GB.hb), .H_DISP(GB.hd), .H_FRONT(GB.hf),
    .V_SYNC(GB.vs), .V_BACK(GB.vb), .V_DISP(GB.vd), .V_FRONT(GB.vf),
    .PIX_LAT(GB.lat)
  ) dut_b (
    .clk_33_3m(clk), .rst(rst[1]), .x_pos(x_pos[1]), .y_pos(y_pos[1]),
    .data_req(data_req[1]), .display_data(display_data[1]),
    .tft_hs(tft_hs[1]), .tft_vs(tft_vs[1]), .tft_de(tft_de[1]),
    .tft_rgb(tft_rgb[1]), .frame_start(frame_start[1])
  );

  tft_timing_driver #(
    .H_SYNC(GC.hs), .H_BACK(GC.hb), .H_DISP(GC.hd), .H_FRONT(GC.hf),
    .V_SYNC(GC.vs), .V_BACK(GC.vb), .V_DISP(GC.vd), .V_FRONT(GC.vf),
    .PIX_LAT(GC.lat)
  ) dut_c (
    .clk_33_3m(clk), .rst(rst[2]), .x_pos(x_pos[2]), .y_pos(y_pos[2]),
    .data_req(data_req[2]), .display_data(display_data[2]),
    .tft_hs(tft_hs[2]), .tft_vs(tft_vs[2]), .tft_de(tft_de[2]),
    .tft_rgb(tft_rgb[2]), .frame_start(frame_start[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs k clocks after reset release, from raster arithmetic:
  // the coordinate side follows position k, the panel side follows
  // position k-lat-1 (reset levels before that exists).
  function automatic exp_t model(input geom_t g, input int k_in);
    exp_t e;
    int ht, vt, ha, va, pos, h, v, p;
    bit act;
    ht  = g.hs + g.hb + g.hd + g.hf;
    vt  = g.vs + g.vb + g.vd + g.vf;
    ha  = g.hs + g.hb;
    va  = g.vs + g.vb;
    pos = k_in % (ht * vt);
    h   = pos % ht;
    v   = pos / ht;
    act = (h >= ha) && (h < ha + g.hd) && (v >= va) && (v < va + g.vd);
    e.req = act;
    e.x   = act ? 11'(h - ha) : 11'd0;
    e.y   = act ? 11'(v - va) : 11'd0;
    p = k_in - g.lat - 1;
    if (p < 0) begin
      e.hs  = 1'b1;
      e.vs  = 1'b1;
      e.de  = 1'b0;
      e.fs  = 1'b0;
      e.rgb = 16'h0000;
    end else begin
      pos = p % (ht * vt);
      h   = pos % ht;
      v   = pos / ht;
      act = (h >= ha) && (h < ha + g.hd) && (v >= va) && (v < va + g.vd);
      e.hs  = (h >= g.hs);
      e.vs  = (v >= g.vs);
      e.de  = act;
      e.fs  = act && (h == ha) && (v == va);
      e.rgb = act ? {5'(v - va), 11'(h - ha)} : 16'h0000;
    end
    return e;
  endfunction

  initial begin
    exp_t e;
    geo[0] = GA;
    geo[1] = GB;
    geo[2] = GC;
    mid_done = 1'b0;
    for (int d = 0; d < 3; d++) begin
      rst[d]          = 1'b1;
      display_data[d] = 16'h0000;
      k[d]            = 0;
      rst_left[d]     = 0;
      for (int j = 0; j < 4; j++) stub[d][j] = 16'h0000;
    end

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        // rst still holds the level the DUT saw at the edge just passed
        k[d] = rst[d] ? 0 : k[d] + 1;
        e = model(geo[d], k[d]);
        chk($sformatf("d%0d_x_pos", d),    32'(x_pos[d]),      32'(e.x));
        chk($sformatf("d%0d_y_pos", d),    32'(y_pos[d]),      32'(e.y));
        chk($sformatf("d%0d_data_req", d), 32'(data_req[d]),   32'(e.req));
        chk($sformatf("d%0d_tft_hs", d),   32'(tft_hs[d]),     32'(e.hs));
        chk($sformatf("d%0d_tft_vs", d),   32'(tft_vs[d]),     32'(e.vs));
        chk($sformatf("d%0d_tft_de", d),   32'(tft_de[d]),     32'(e.de));
        chk($sformatf("d%0d_frame_st", d), 32'(frame_start[d]), 32'(e.fs));
        chk($sformatf("d%0d_tft_rgb", d),  32'(tft_rgb[d]),    32'(e.rgb));

        // Stub pixel source: stub[d][j] holds the reply to the request made
        // j cycles ago; the DUT samples it at the end of this cycle.
        for (int j = 3; j > 0; j--) stub[d][j] = stub[d][j-1];
        stub[d][0] = data_req[d] ? {y_pos[d][4:0], x_pos[d]} : 16'($urandom);
        display_data[d] = stub[d][geo[d].lat];
      end

      // Reset schedule for the next edge
      if (cyc < 9) begin
        for (int d = 0; d < 3; d++) rst[d] = 1'b1;
      end else begin
        rst[0] = 1'b0;
        for (int d = 1; d < 3; d++) begin
          if (rst_left[d] > 0) begin
            rst[d] = 1'b1;
            rst_left[d]--;
          end else begin
            rst[d] = 1'b0;
            if ($urandom_range(0, 599) == 0) begin
              rst[d] = 1'b1;
              rst_left[d] = $urandom_range(0, 2);
            end
          end
        end
        // Mid-line, mid-frame reset on a visible pixel of the reduced panel
        if (!mid_done && cyc > 3000 && data_req[1] &&
            x_pos[1] == 11'd5 && y_pos[1] == 11'd3) begin
          rst[1]   = 1'b1;
          mid_done = 1'b1;
        end
      end
    end

    chk("mid_reset_hit", 32'(mid_done), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
